muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. Sits beside the ALU in EX. It accepts MULT/MULTU/DIV/DIVU from the decode/EX controls and runs them over 34 cycles as a shift-add multiplier or restoring divider. While running it drives a busy signal that the hazard logic uses to stall the pipeline. It also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.

---
 rtl/muldiv_pkg.sv | 12 +
 rtl/muldiv_if.sv | 17 +
 rtl/muldiv_step.sv | 20 ++
 rtl/muldiv_unit.sv | 109 ++++++++++
 tb/tb_muldiv_unit.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and sizes for the iterative multiply/divide unit
package muldiv_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int CNT_W = $clog2(DEF_WIDTH);
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: EX-stage control/operand bundle and HI/LO results of the muldiv unit
interface muldiv_if #(parameter int W = 32);
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs;
  logic [W-1:0] rt;
  logic         flush;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  modport master (output start, op, rs, rt, flush, hi_we, lo_we, wdata, input busy, done, hi, lo);
  modport slave  (input start, op, rs, rt, flush, hi_we, lo_we, wdata, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring divide iteration on {upper, lower}
module muldiv_step #(parameter int W = 32) (
  input  logic         div_i,
  input  logic [W-1:0] upper_i,
  input  logic [W-1:0] lower_i,
  input  logic [W-1:0] opnd_i,
  output logic [W-1:0] upper_o,
  output logic [W-1:0] lower_o
);
  logic [W:0]   sum;
  logic [W-1:0] trial;
  logic         ge;
  always_comb begin
    sum     = {1'b0, upper_i} + (lower_i[0] ? {1'b0, opnd_i} : '0);
    ge      = {upper_i, lower_i[W-1]} >= {1'b0, opnd_i};
    trial   = {upper_i[W-2:0], lower_i[W-1]} - opnd_i;
    upper_o = div_i ? (ge ? trial : {upper_i[W-2:0], lower_i[W-1]}) : sum[W:1];
    lower_o = div_i ? {lower_i[W-2:0], ge} : {sum[0], lower_i[W-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(parameter int WIDTH = DEF_WIDTH) (
  input logic      clk,
  input logic      rst_n,
  muldiv_if.slave  md_io
);
  localparam int CW = $clog2(WIDTH);
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] rs_q, rs_d, opnd_q, opnd_d, acc_q, acc_d, low_q, low_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] step_hi, step_lo, abs_rs, abs_rt, quo, rem, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;
  logic             busy, launch, sgn, neg;

  assign busy   = state_q == CALC || state_q == FIX;
  assign launch = md_io.start && !md_io.flush && (state_q == IDLE || state_q == DONE);
  assign sgn    = !md_io.op[0];
  assign abs_rs = sgn && md_io.rs[WIDTH-1] ? -md_io.rs : md_io.rs;
  assign abs_rt = sgn && md_io.rt[WIDTH-1] ? -md_io.rt : md_io.rt;
  // Sign latches are zero for unsigned ops, so the fix-up is a no-op there.
  assign neg    = sa_q ^ sb_q;
  assign prod   = neg ? -{acc_q, low_q} : {acc_q, low_q};
  assign quo    = neg ? -low_q : low_q;
  assign rem    = sa_q ? -acc_q : acc_q;
  assign fix_hi = !op_q[1] ? prod[2*WIDTH-1:WIDTH] : opnd_q == '0 ? rs_q : rem;
  assign fix_lo = !op_q[1] ? prod[WIDTH-1:0] : opnd_q == '0 ? '1 : quo;

  muldiv_step #(.W(WIDTH)) u_step (
    .div_i   (op_q[1]),
    .upper_i (acc_q),
    .lower_i (low_q),
    .opnd_i  (opnd_q),
    .upper_o (step_hi),
    .lower_o (step_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    rs_d    = rs_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    low_d   = low_q;
    hi_d    = !busy && md_io.hi_we ? md_io.wdata : hi_q;
    lo_d    = !busy && md_io.lo_we ? md_io.wdata : lo_q;
    if (md_io.flush) state_d = IDLE;
    else if (launch) begin
      state_d = CALC;
      cnt_d   = '0;
      op_d    = md_io.op;
      sa_d    = sgn & md_io.rs[WIDTH-1];
      sb_d    = sgn & md_io.rt[WIDTH-1];
      rs_d    = md_io.rs;
      opnd_d  = md_io.op[1] ? abs_rt : abs_rs;
      low_d   = md_io.op[1] ? abs_rs : abs_rt;
      acc_d   = '0;
    end else if (state_q == CALC) begin
      acc_d   = step_hi;
      low_d   = step_lo;
      cnt_d   = cnt_q + 1'b1;
      state_d = cnt_q == CW'(WIDTH - 1) ? FIX : CALC;
    end else if (state_q == FIX) begin
      hi_d    = fix_hi;
      lo_d    = fix_lo;
      state_d = DONE;
    end else if (state_q == DONE) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      rs_q    <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      low_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      rs_q    <= rs_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      low_q   <= low_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md_io.busy = busy;
  assign md_io.done = state_q == DONE;
  assign md_io.hi   = hi_q;
  assign md_io.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for the iterative multiply/divide unit
module tb_muldiv_unit;
  import muldiv_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [63:0] exp_q[$];
  int n, bc, dn;

  muldiv_if #(.W(32)) bus();
  muldiv_unit dut (.clk(clk), .rst_n(rst_n), .md_io(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return {32'b0, a} * {32'b0, b};
      OP_DIV:   return b == 0 ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
      default:  return b == 0 ? {a, 32'hFFFFFFFF} : {a % b, a / b};
    endcase
  endfunction

  always @(negedge clk) if (bus.done) begin
    check("sb_pending", 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) check("hi_lo", {bus.hi, bus.lo}, exp_q.pop_front());
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    bus.start = 1'b1;
    bus.op = op;
    bus.rs = a;
    bus.rt = b;
    if (push) exp_q.push_back(model(op, a, b));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // n counts negedges since launch; start is pulsed at cycle poke to prove it is ignored
  task automatic wait_done(input int n0, input int poke, output int nn, output int bcnt);
    nn = n0;
    bcnt = 0;
    while (!bus.done && nn < 100) begin
      bcnt += int'(bus.busy);
      bus.start = (nn == poke);
      @(negedge clk);
      nn++;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    {bus.start, bus.flush, bus.hi_we, bus.lo_we} = '0;
    bus.op = '0;
    bus.rs = '0;
    bus.rt = '0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(OP_MULT, 32'd7, 32'hFFFFFFFD, 1'b1);
    wait_done(1, 0, n, bc);
    check("mult_lat", 64'(n), 64'd34);
    check("mult_busy", 64'(bc), 64'd33);
    check("mult_val", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFEB);
    @(negedge clk);
    check("done_pulse", 64'(bus.done), 64'd0);

    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_done(1, 0, n, bc);
    check("multu_lat", 64'(n), 64'd34);
    check("multu_val", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
    issue(OP_DIVU, 32'd100, 32'd7, 1'b1);
    check("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done(1, 0, n, bc);
    check("b2b_lat", 64'(n), 64'd34);
    check("divu_val", {bus.hi, bus.lo}, 64'h00000002_0000000E);
    @(negedge clk);

    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
    wait_done(1, 0, n, bc);
    check("div_val", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    @(negedge clk);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_done(1, 0, n, bc);
    check("div_ovf", {bus.hi, bus.lo}, 64'h00000000_80000000);
    @(negedge clk);
    issue(OP_DIV, 32'hC0000001, 32'h00000005, 1'b1);
    wait_done(1, 0, n, bc);
    @(negedge clk);
    issue(OP_MULT, 32'h80000000, 32'h7FFFFFFF, 1'b1);
    wait_done(1, 0, n, bc);
    @(negedge clk);

    issue(OP_DIV, 32'h12345678, 32'd0, 1'b1);
    wait_done(1, 10, n, bc);
    check("dz_lat", 64'(n), 64'd34);
    check("dz_val", {bus.hi, bus.lo}, 64'h12345678_FFFFFFFF);
    @(negedge clk);
    check("dz_idle", 64'(bus.busy), 64'd0);

    bus.hi_we = 1'b1;
    bus.wdata = 32'hAAAA0000;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("mthi", {bus.hi, bus.lo}, 64'hAAAA0000_FFFFFFFF);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h00005555;
    @(negedge clk);
    bus.lo_we = 1'b0;
    check("mtlo", {bus.hi, bus.lo}, 64'hAAAA0000_00005555);

    issue(OP_MULTU, 32'd3, 32'd5, 1'b1);
    repeat (4) @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h12121212;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("mt_drop", 64'(bus.hi), 64'hAAAA0000);
    wait_done(6, 0, n, bc);
    check("drop_lat", 64'(n), 64'd34);
    @(negedge clk);

    bus.hi_we = 1'b1;
    bus.wdata = 32'hBEEF0000;
    issue(OP_DIVU, 32'd50, 32'd5, 1'b1);
    bus.hi_we = 1'b0;
    check("mt_with_start", 64'(bus.hi), 64'hBEEF0000);
    wait_done(1, 0, n, bc);
    check("overwrite", {bus.hi, bus.lo}, 64'h00000000_0000000A);
    @(negedge clk);

    issue(OP_MULT, 32'h1234, 32'h5678, 1'b0);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'd0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      dn += int'(bus.done);
    end
    check("flush_nodone", 64'(dn), 64'd0);
    check("flush_keep", {bus.hi, bus.lo}, 64'h00000000_0000000A);
    bus.flush = 1'b1;
    bus.start = 1'b1;
    bus.op = OP_MULTU;
    @(negedge clk);
    {bus.flush, bus.start} = '0;
    check("flush_start", 64'(bus.busy), 64'd0);

    bus.hi_we = 1'b1;
    bus.wdata = 32'h77;
    @(negedge clk);
    bus.hi_we = 1'b0;
    issue(OP_MULTU, 32'd9, 32'd9, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
